axi_ram_slave: RTL and testbench

AXI_RAM_SLAVE -- requirements
Module: axi_ram_slave

---
 rtl/axi_ram_slave.sv | 172 +++++++++++++++++
 tb/tb_axi_ram_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// AXI4 RAM slave: independent write and read burst engines sharing one
// word-addressed storage array (one write port, one combinational read port).
module axi_ram_slave #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_WIDTH-1:0]   i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  output logic                    o_bvalid,
  input  logic                    i_bready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [ADDR_WIDTH-1:0]   i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rlast,
  output logic [1:0]              o_rresp
);

  localparam int IDX_W  = $clog2(MEM_DEPTH);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // FIXED holds the index; INCR, WRAP and reserved all step by one, wrapping at the top.
  function automatic logic [IDX_W-1:0] f_next_idx(input logic [IDX_W-1:0] idx,
                                                  input logic [1:0] burst);
    return (burst == 2'b00) ? idx : idx + IDX_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  w_state_t         r_wstate, w_wstate_nxt;
  logic [ID_WIDTH-1:0] r_wid;
  logic [IDX_W-1:0] r_widx;
  logic [7:0]       r_wlen, r_wcnt;
  logic [1:0]       r_wburst, r_bresp;
  logic             w_aw_hs, w_w_hs, w_wend;

  r_state_t         r_rstate, w_rstate_nxt;
  logic [ID_WIDTH-1:0] r_rid;
  logic [IDX_W-1:0] r_ridx;
  logic [7:0]       r_rlen, r_rcnt;
  logic [1:0]       r_rburst;
  logic             w_ar_hs, w_r_hs;
  logic             w_unused;

  assign w_unused = ^{i_awsize, i_arsize, i_awaddr, i_araddr};

  assign o_awready = (r_wstate == W_IDLE);
  assign o_wready  = (r_wstate == W_DATA);
  assign o_bvalid  = (r_wstate == W_RESP);
  assign o_bid     = r_wid;
  assign o_bresp   = r_bresp;
  assign w_aw_hs   = i_awvalid & o_awready;
  assign w_w_hs    = i_wvalid & o_wready;
  // The burst closes on whichever comes first: the length count or WLAST.
  assign w_wend    = (r_wcnt == r_wlen) | i_wlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wstate <= W_IDLE;
    else        r_wstate <= w_wstate_nxt;
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE: if (i_awvalid) w_wstate_nxt = W_DATA; else w_wstate_nxt = W_IDLE;
      W_DATA: if (i_wvalid && w_wend) w_wstate_nxt = W_RESP; else w_wstate_nxt = W_DATA;
      W_RESP: if (i_bready) w_wstate_nxt = W_IDLE; else w_wstate_nxt = W_RESP;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wid    <= '0;
      r_widx   <= '0;
      r_wlen   <= 8'd0;
      r_wcnt   <= 8'd0;
      r_wburst <= 2'b00;
      r_bresp  <= 2'b00;
    end else if (w_aw_hs) begin
      r_wid    <= i_awid;
      r_widx   <= i_awaddr[IDX_W-1:0];
      r_wlen   <= i_awlen;
      r_wcnt   <= 8'd0;
      r_wburst <= i_awburst;
    end else if (w_w_hs) begin
      r_wcnt <= r_wcnt + 8'd1;
      r_widx <= f_next_idx(r_widx, r_wburst);
      // SLVERR unless WLAST lands exactly on the final counted beat.
      if (w_wend) r_bresp <= ((r_wcnt == r_wlen) && i_wlast) ? 2'b00 : 2'b10;
    end
  end

  // Storage is deliberately not reset so completed writes survive rst_n.
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (i_wstrb[i]) r_mem[r_widx][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_arready = (r_rstate == R_IDLE);
  assign o_rvalid  = (r_rstate == R_DATA);
  assign o_rlast   = (r_rstate == R_DATA) && (r_rcnt == r_rlen);
  assign o_rid     = r_rid;
  assign o_rresp   = 2'b00;
  // Combinational read gives pre-write data when the write port hits the same word.
  assign o_rdata   = r_mem[r_ridx];
  assign w_ar_hs   = i_arvalid & o_arready;
  assign w_r_hs    = o_rvalid & i_rready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rstate <= R_IDLE;
    else        r_rstate <= w_rstate_nxt;
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE: if (i_arvalid) w_rstate_nxt = R_DATA; else w_rstate_nxt = R_IDLE;
      R_DATA: if (i_rready && o_rlast) w_rstate_nxt = R_IDLE; else w_rstate_nxt = R_DATA;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rid    <= '0;
      r_ridx   <= '0;
      r_rlen   <= 8'd0;
      r_rcnt   <= 8'd0;
      r_rburst <= 2'b00;
    end else if (w_ar_hs) begin
      r_rid    <= i_arid;
      r_ridx   <= i_araddr[IDX_W-1:0];
      r_rlen   <= i_arlen;
      r_rcnt   <= 8'd0;
      r_rburst <= i_arburst;
    end else if (w_r_hs) begin
      r_rcnt <= r_rcnt + 8'd1;
      r_ridx <= f_next_idx(r_ridx, r_rburst);
    end
  end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomized bench for axi_ram_slave against a word-array reference model
// that applies the burst addressing and response rules directly.
module tb_axi_ram_slave;

  localparam int ID_W  = 4;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4096;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_awvalid, o_awready, i_wvalid, o_wready, i_wlast;
  logic          o_bvalid, i_bready, i_arvalid, o_arready;
  logic          o_rvalid, i_rready, o_rlast;
  logic [ID_W-1:0] i_awid, o_bid, i_arid, o_rid;
  logic [AW-1:0] i_awaddr, i_araddr;
  logic [7:0]    i_awlen, i_arlen;
  logic [2:0]    i_awsize, i_arsize;
  logic [1:0]    i_awburst, i_arburst, o_bresp, o_rresp;
  logic [DW-1:0] i_wdata, o_rdata;
  logic [0:0]    i_wstrb;

  logic [7:0] model [DEPTH];
  logic [7:0] wbuf_data [256];
  logic       wbuf_strb [256];
  int n_checks = 0;
  int n_fail   = 0;

  axi_ram_slave #(.ID_WIDTH(ID_W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_awvalid(i_awvalid), .o_awready(o_awready), .i_awid(i_awid), .i_awaddr(i_awaddr),
    .i_awlen(i_awlen), .i_awsize(i_awsize), .i_awburst(i_awburst),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata), .i_wstrb(i_wstrb), .i_wlast(i_wlast),
    .o_bvalid(o_bvalid), .i_bready(i_bready), .o_bid(o_bid), .o_bresp(o_bresp),
    .i_arvalid(i_arvalid), .o_arready(o_arready), .i_arid(i_arid), .i_araddr(i_araddr),
    .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arburst(i_arburst),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rid(o_rid), .o_rdata(o_rdata),
    .o_rlast(o_rlast), .o_rresp(o_rresp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int beat_idx(input int idx0, input logic [1:0] burst, input int b);
    return (burst == 2'b00) ? idx0 : (idx0 + b) % DEPTH;
  endfunction

  // Called and returns at a falling edge; data comes from wbuf_data/wbuf_strb.
  task automatic axi_write(input logic [3:0] id, input logic [15:0] addr, input int len,
                           input logic [1:0] burst, input int nbeats, input bit wlast_end,
                           input int bwait, input bit gaps);
    int t;
    int idx0;
    logic [1:0] exp_resp;
    idx0 = int'(addr) % DEPTH;
    i_awvalid = 1'b1; i_awid = id; i_awaddr = addr; i_awlen = len[7:0];
    i_awsize = 3'd0; i_awburst = burst;
    t = 0;
    while (!o_awready && t < 300) begin @(negedge clk); t++; end
    check_eq("aw_accept", {31'd0, o_awready}, 32'd1);
    @(negedge clk);
    i_awvalid = 1'b0;
    check_eq("wready_after_aw", {31'd0, o_wready}, 32'd1);
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        i_wvalid = 1'b0;
        repeat ($urandom_range(2)) @(negedge clk);
      end
      i_wvalid = 1'b1; i_wdata = wbuf_data[b]; i_wstrb = wbuf_strb[b];
      i_wlast = (b == nbeats - 1) && wlast_end;
      t = 0;
      while (!o_wready && t < 300) begin @(negedge clk); t++; end
      check_eq("w_accept", {31'd0, o_wready}, 32'd1);
      if (wbuf_strb[b]) model[beat_idx(idx0, burst, b)] = wbuf_data[b];
      @(negedge clk);
    end
    i_wvalid = 1'b0; i_wlast = 1'b0;
    exp_resp = (nbeats == len + 1 && wlast_end) ? 2'b00 : 2'b10;
    check_eq("bvalid", {31'd0, o_bvalid}, 32'd1);
    i_bready = 1'b0;
    repeat (bwait) begin
      @(negedge clk);
      check_eq("bvalid_hold", {31'd0, o_bvalid}, 32'd1);
      check_eq("bid_hold", {28'd0, o_bid}, {28'd0, id});
    end
    i_bready = 1'b1;
    check_eq("bid", {28'd0, o_bid}, {28'd0, id});
    check_eq("bresp", {30'd0, o_bresp}, {30'd0, exp_resp});
    @(negedge clk);
    i_bready = 1'b0;
    check_eq("awready_after_b", {31'd0, o_awready}, 32'd1);
    check_eq("bvalid_after_b", {31'd0, o_bvalid}, 32'd0);
  endtask

  // rmode 0: RREADY always high, 1: toggling 1-0-1, 2: random.
  task automatic axi_read(input logic [3:0] id, input logic [15:0] addr, input int len,
                          input logic [1:0] burst, input int rmode);
    logic [7:0] exp_q[$];
    logic [7:0] prev_data;
    logic       prev_last, stalled;
    int t, beat, idx0;
    idx0 = int'(addr) % DEPTH;
    for (int k = 0; k <= len; k++) exp_q.push_back(model[beat_idx(idx0, burst, k)]);
    i_arvalid = 1'b1; i_arid = id; i_araddr = addr; i_arlen = len[7:0];
    i_arsize = 3'd0; i_arburst = burst;
    t = 0;
    while (!o_arready && t < 300) begin @(negedge clk); t++; end
    check_eq("ar_accept", {31'd0, o_arready}, 32'd1);
    @(negedge clk);
    i_arvalid = 1'b0;
    check_eq("rvalid_after_ar", {31'd0, o_rvalid}, 32'd1);
    beat = 0; t = 0; stalled = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    while (beat <= len && t < 2000) begin
      i_rready = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((t % 2) == 0) : 1'($urandom_range(1));
      if (stalled) begin
        check_eq("rdata_stall", {24'd0, o_rdata}, {24'd0, prev_data});
        check_eq("rlast_stall", {31'd0, o_rlast}, {31'd0, prev_last});
        check_eq("rid_stall", {28'd0, o_rid}, {28'd0, id});
      end
      if (o_rvalid && i_rready) begin
        check_eq("rdata", {24'd0, o_rdata}, {24'd0, exp_q[beat]});
        check_eq("rlast", {31'd0, o_rlast}, {31'd0, (beat == len)});
        check_eq("rid", {28'd0, o_rid}, {28'd0, id});
        check_eq("rresp", {30'd0, o_rresp}, 32'd0);
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = o_rvalid;
        prev_data = o_rdata;
        prev_last = o_rlast;
      end
      @(negedge clk);
      t++;
    end
    i_rready = 1'b0;
    check_eq("r_beats", beat, len + 1);
    check_eq("rvalid_after_last", {31'd0, o_rvalid}, 32'd0);
    check_eq("arready_after_last", {31'd0, o_arready}, 32'd1);
  endtask

  task automatic fill_wbuf(input int n, input bit rnd_strb);
    for (int b = 0; b < n; b++) begin
      wbuf_data[b] = 8'($urandom);
      wbuf_strb[b] = rnd_strb ? 1'($urandom_range(1)) : 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_awvalid = 1'b0; i_awid = 4'd0; i_awaddr = 16'd0; i_awlen = 8'd0; i_awsize = 3'd0; i_awburst = 2'b01;
    i_wvalid = 1'b0; i_wdata = 8'd0; i_wstrb = 1'b0; i_wlast = 1'b0; i_bready = 1'b0;
    i_arvalid = 1'b0; i_arid = 4'd0; i_araddr = 16'd0; i_arlen = 8'd0; i_arsize = 3'd0; i_arburst = 2'b01;
    i_rready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_awready", {31'd0, o_awready}, 32'd1);
    check_eq("rst_arready", {31'd0, o_arready}, 32'd1);
    check_eq("rst_wready", {31'd0, o_wready}, 32'd0);
    check_eq("rst_bvalid", {31'd0, o_bvalid}, 32'd0);
    check_eq("rst_rvalid", {31'd0, o_rvalid}, 32'd0);
    check_eq("rst_rlast", {31'd0, o_rlast}, 32'd0);
    check_eq("rst_bresp", {30'd0, o_bresp}, 32'd0);
    check_eq("rst_rresp", {30'd0, o_rresp}, 32'd0);
    check_eq("rst_bid", {28'd0, o_bid}, 32'd0);
    check_eq("rst_rid", {28'd0, o_rid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Initialise every word with 256-beat bursts so the model is fully known.
    for (int blk = 0; blk < DEPTH / 256; blk++) begin
      fill_wbuf(256, 1'b0);
      axi_write(4'(blk), 16'(blk * 256), 255, 2'b01, 256, 1'b1, 0, 1'b0);
    end
    axi_read(4'h1, 16'h0300, 255, 2'b01, 0);

    wbuf_data[0] = 8'hA1; wbuf_data[1] = 8'hB2; wbuf_data[2] = 8'hC3; wbuf_data[3] = 8'hD4;
    for (int b = 0; b < 4; b++) wbuf_strb[b] = 1'b1;
    axi_write(4'h5, 16'h0010, 3, 2'b01, 4, 1'b1, 0, 1'b0);
    axi_read(4'h9, 16'h0010, 3, 2'b01, 0);

    wbuf_data[0] = 8'h11; wbuf_data[1] = 8'h22;
    axi_write(4'h2, 16'h0FFF, 1, 2'b01, 2, 1'b1, 0, 1'b0);
    axi_read(4'h3, 16'h0FFF, 0, 2'b01, 0);
    axi_read(4'h4, 16'h0000, 0, 2'b01, 0);
    axi_read(4'h6, 16'hFFFF, 1, 2'b10, 0);

    fill_wbuf(4, 1'b0);
    axi_write(4'hA, 16'h0040, 3, 2'b01, 4, 1'b1, 5, 1'b0);
    axi_read(4'hB, 16'h0040, 3, 2'b01, 1);

    fill_wbuf(4, 1'b0);
    axi_write(4'hC, 16'h0080, 3, 2'b01, 2, 1'b1, 0, 1'b0);
    axi_read(4'hC, 16'h0080, 3, 2'b01, 0);
    fill_wbuf(3, 1'b0);
    wbuf_strb[1] = 1'b0;
    axi_write(4'hD, 16'h00A0, 2, 2'b01, 3, 1'b1, 0, 1'b0);
    axi_read(4'hD, 16'h00A0, 2, 2'b01, 0);
    fill_wbuf(3, 1'b0);
    axi_write(4'hE, 16'h00B0, 2, 2'b01, 3, 1'b0, 1, 1'b0);
    fill_wbuf(4, 1'b0);
    axi_write(4'h7, 16'h00C0, 3, 2'b00, 4, 1'b1, 0, 1'b1);
    axi_read(4'h7, 16'h00C0, 2, 2'b00, 0);
    axi_read(4'h7, 16'h00BF, 2, 2'b01, 0);

    fill_wbuf(4, 1'b0);
    fork
      axi_write(4'h1, 16'h0500, 3, 2'b01, 4, 1'b1, 0, 1'b0);
      axi_read(4'h2, 16'h0600, 3, 2'b01, 0);
    join
    axi_read(4'h3, 16'h0500, 3, 2'b01, 0);

    // Same-cycle write and read of one word: read sees the old value.
    wbuf_data[0] = 8'h5A; wbuf_strb[0] = 1'b1;
    axi_write(4'h1, 16'h0200, 0, 2'b01, 1, 1'b1, 0, 1'b0);
    i_awvalid = 1'b1; i_awid = 4'h2; i_awaddr = 16'h0200; i_awlen = 8'd0; i_awburst = 2'b01;
    i_arvalid = 1'b1; i_arid = 4'h3; i_araddr = 16'h0200; i_arlen = 8'd0; i_arburst = 2'b01;
    check_eq("coll_awready", {31'd0, o_awready}, 32'd1);
    check_eq("coll_arready", {31'd0, o_arready}, 32'd1);
    @(negedge clk);
    i_awvalid = 1'b0; i_arvalid = 1'b0;
    i_wvalid = 1'b1; i_wdata = 8'hC7; i_wstrb = 1'b1; i_wlast = 1'b1; i_rready = 1'b1;
    check_eq("coll_wready", {31'd0, o_wready}, 32'd1);
    check_eq("coll_rvalid", {31'd0, o_rvalid}, 32'd1);
    check_eq("coll_old_data", {24'd0, o_rdata}, 32'h5A);
    @(negedge clk);
    i_wvalid = 1'b0; i_wlast = 1'b0; i_rready = 1'b0;
    model[16'h0200] = 8'hC7;
    check_eq("coll_bvalid", {31'd0, o_bvalid}, 32'd1);
    check_eq("coll_rdone", {31'd0, o_rvalid}, 32'd0);
    i_bready = 1'b1;
    @(negedge clk);
    i_bready = 1'b0;
    axi_read(4'h4, 16'h0200, 0, 2'b01, 0);

    // Reset while beat 2 of a burst is being offered.
    i_awvalid = 1'b1; i_awid = 4'h8; i_awaddr = 16'h0300; i_awlen = 8'd3; i_awburst = 2'b01;
    @(negedge clk);
    i_awvalid = 1'b0;
    i_wvalid = 1'b1; i_wdata = 8'hE1; i_wstrb = 1'b1; i_wlast = 1'b0;
    @(negedge clk);
    model[16'h0300] = 8'hE1;
    i_wdata = 8'hE2;
    #1 rst_n = 1'b0;
    @(negedge clk);
    i_wvalid = 1'b0;
    check_eq("rstmid_awready", {31'd0, o_awready}, 32'd1);
    check_eq("rstmid_wready", {31'd0, o_wready}, 32'd0);
    check_eq("rstmid_bvalid", {31'd0, o_bvalid}, 32'd0);
    check_eq("rstmid_rvalid", {31'd0, o_rvalid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(4'h9, 16'h0300, 1, 2'b01, 0);

    for (int it = 0; it < 40; it++) begin
      int op, len, nb;
      bit wl;
      logic [15:0] addr;
      logic [1:0] burst;
      op = $urandom_range(2);
      addr = 16'($urandom);
      len = ($urandom_range(7) == 0) ? $urandom_range(40) : $urandom_range(7);
      burst = 2'($urandom_range(3));
      nb = len + 1;
      wl = 1'b1;
      if (len > 0 && $urandom_range(4) == 0) nb = 1 + $urandom_range(len - 1);
      else wl = ($urandom_range(5) != 0);
      fill_wbuf(nb, 1'b1);
      if (op == 0) axi_write(4'($urandom), addr, len, burst, nb, wl, $urandom_range(3), 1'b1);
      else if (op == 1) axi_read(4'($urandom), addr, len, burst, 2);
      else fork
        axi_write(4'($urandom), addr, len, burst, nb, wl, $urandom_range(3), 1'b1);
        axi_read(4'($urandom), addr ^ 16'h0800, len, burst, 2);
      join
    end
    axi_read(4'h5, 16'h0000, 255, 2'b01, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
